// File: rtl/pong_pkg.sv
// Shared Pong constants: visible screen size, paddle geometry and the ball motion states.
package pong_pkg;

    localparam logic [11:0] SCREEN_W = 12'd800;
    localparam logic [11:0] SCREEN_H = 12'd600;

    // Left paddle spans x = PAD_L_X-PAD_W .. PAD_L_X-1; its face is PAD_L_X.
    localparam logic [11:0] PAD_W    = 12'd10;
    localparam logic [11:0] PAD_LEN  = 12'd80;
    localparam logic [11:0] PAD_L_X  = 12'd60;
    localparam logic [11:0] PAD_R_X  = 12'd707;

    typedef enum logic {
        SERVE,
        MOVE
    } state_e;

endpackage

// File: rtl/ball_ctl.sv
// Ball motion controller: detects the start of vertical blanking and advances the ball
// once per frame, handling wall and paddle bounces, scoring and re-serve.
//
// state | meaning
// SERVE | ball parked at centre, counting frames until it is launched
// MOVE  | ball travels SPEED px per axis per frame
module ball_ctl
    import pong_pkg::*;
#(
    parameter int BALL_SIZE    = 8,
    parameter int SPEED        = 4,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        vblnk_i,
    input  logic [11:0] y_pos_i,
    input  logic [11:0] y_pos_sec_i,
    input  logic        enable_i,
    output logic [11:0] ball_x_o,
    output logic [11:0] ball_y_o,
    output logic        point_l_o,
    output logic        point_r_o
);

    localparam int          CNT_W      = $clog2(SERVE_FRAMES);
    localparam logic [11:0] BALL_W     = 12'(BALL_SIZE);
    localparam logic [11:0] SPD        = 12'(SPEED);
    localparam logic [11:0] CENTRE_X   = 12'((int'(SCREEN_W) - BALL_SIZE) / 2);
    localparam logic [11:0] CENTRE_Y   = 12'((int'(SCREEN_H) - BALL_SIZE) / 2);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [11:0]        x_q, x_d, y_q, y_d;
    logic               dir_x_q, dir_x_d;   // 1 = right
    logic               dir_y_q, dir_y_d;   // 1 = down
    logic               point_l_q, point_l_d, point_r_q, point_r_d;
    logic               vblnk_q;
    logic               frame_tick, hit_l, hit_r;

    assign frame_tick = vblnk_i & ~vblnk_q;
    assign hit_l = (y_q + BALL_W > y_pos_i) && (y_q < y_pos_i + PAD_LEN);
    assign hit_r = (y_q + BALL_W > y_pos_sec_i) && (y_q < y_pos_sec_i + PAD_LEN);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        point_l_d = 1'b0;
        point_r_d = 1'b0;
        if (!enable_i) begin
            state_d = SERVE;
            cnt_d   = '0;
            x_d     = CENTRE_X;
            y_d     = CENTRE_Y;
        end else if (frame_tick) begin
            if (state_q == SERVE) begin
                if (cnt_q == SERVE_LAST) begin
                    state_d = MOVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                if (dir_y_q) begin
                    if (y_q + BALL_W + SPD >= SCREEN_H) begin
                        y_d     = SCREEN_H - BALL_W;
                        dir_y_d = 1'b0;
                    end else begin
                        y_d = y_q + SPD;
                    end
                end else begin
                    if (y_q < SPD) begin
                        y_d     = '0;
                        dir_y_d = 1'b1;
                    end else begin
                        y_d = y_q - SPD;
                    end
                end
                // x_q >= PAD_L_X guarantees x_q >= SPD, so x_q - SPD cannot wrap there.
                if (!dir_x_q) begin
                    if (x_q >= PAD_L_X && (x_q - SPD) < PAD_L_X && hit_l) begin
                        x_d     = PAD_L_X;
                        dir_x_d = 1'b1;
                    end else if (x_q < SPD) begin
                        point_r_d = 1'b1;
                        x_d       = CENTRE_X;
                        y_d       = CENTRE_Y;
                        dir_x_d   = 1'b0;
                        state_d   = SERVE;
                        cnt_d     = '0;
                    end else begin
                        x_d = x_q - SPD;
                    end
                end else begin
                    if (x_q + BALL_W <= PAD_R_X && x_q + BALL_W + SPD > PAD_R_X && hit_r) begin
                        x_d     = PAD_R_X - BALL_W;
                        dir_x_d = 1'b0;
                    end else if (x_q + BALL_W + SPD > SCREEN_W) begin
                        point_l_d = 1'b1;
                        x_d       = CENTRE_X;
                        y_d       = CENTRE_Y;
                        dir_x_d   = 1'b1;
                        state_d   = SERVE;
                        cnt_d     = '0;
                    end else begin
                        x_d = x_q + SPD;
                    end
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SERVE;
            cnt_q     <= '0;
            x_q       <= CENTRE_X;
            y_q       <= CENTRE_Y;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            point_l_q <= 1'b0;
            point_r_q <= 1'b0;
            vblnk_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            point_l_q <= point_l_d;
            point_r_q <= point_r_d;
            vblnk_q   <= vblnk_i;
        end
    end

    assign ball_x_o  = x_q;
    assign ball_y_o  = y_q;
    assign point_l_o = point_l_q;
    assign point_r_o = point_r_q;

endmodule

// File: rtl/draw_ball.sv
// Final Pong pixel stage: overlays the ball on the paddle-stage RGB and delays the
// timing bus by one pclk so it stays aligned with the composited pixel.
module draw_ball
    import pong_pkg::*;
#(
    parameter int BALL_SIZE    = 8,
    parameter int SPEED        = 4,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] y_pos,
    input  logic [11:0] y_pos_sec,
    input  logic [11:0] ball_color,
    input  logic        enable,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        point_l,
    output logic        point_r
);

    localparam logic [11:0] BALL_W = 12'(BALL_SIZE);

    logic [11:0] ball_x, ball_y;
    logic [11:0] h_ext, v_ext;
    logic        in_ball;
    logic [11:0] rgb_d, rgb_q;
    logic [10:0] hcount_q, vcount_q;
    logic [3:0]  timing_q;

    ball_ctl #(
        .BALL_SIZE   (BALL_SIZE),
        .SPEED       (SPEED),
        .SERVE_FRAMES(SERVE_FRAMES)
    ) u_ctl (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .vblnk_i    (vblnk_in),
        .y_pos_i    (y_pos),
        .y_pos_sec_i(y_pos_sec),
        .enable_i   (enable),
        .ball_x_o   (ball_x),
        .ball_y_o   (ball_y),
        .point_l_o  (point_l),
        .point_r_o  (point_r)
    );

    assign h_ext   = {1'b0, hcount_in};
    assign v_ext   = {1'b0, vcount_in};
    assign in_ball = (h_ext >= ball_x) && (h_ext < ball_x + BALL_W) &&
                     (v_ext >= ball_y) && (v_ext < ball_y + BALL_W);
    assign rgb_d   = in_ball ? ball_color : rgb_in;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
            timing_q <= '0;
            rgb_q    <= '0;
        end else begin
            hcount_q <= hcount_in;
            vcount_q <= vcount_in;
            timing_q <= {hsync_in, vsync_in, hblnk_in, vblnk_in};
            rgb_q    <= rgb_d;
        end
    end

    assign hcount_out = hcount_q;
    assign vcount_out = vcount_q;
    assign {hsync_out, vsync_out, hblnk_out, vblnk_out} = timing_q;
    assign rgb_out    = rgb_q;

endmodule
